word_regbank: RTL and testbench
===============================

# word_regbank

Parametrised multi-word state register bank, the next generation of the single-word load register. It holds DEPTH words of WIDTH bits and supports four operations on one word per cycle: hold, indexed load, indexed XOR-absorb and serial shift-in with a handshaked shift-out port. It sits between the ASCON permutation datapath and the message/tag interface: the permutation uses the whole bank in parallel, and the I/O side streams words in and out.

## Interface
Parameters:
- WIDTH, default ascon_params::WORD_SIZE: word width in bits.
- DEPTH, default 5: number of words (5 × 64 bits = ASCON state); legal range 2..16.
- ADDR_W, default $clog2(DEPTH): localparam, not overridable.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush of the bank and the output register.
- op  input  2  operation: RB_HOLD=0, RB_LOAD=1, RB_XOR=2, RB_SHIFT=3.
- addr  input  ADDR_W  word index for LOAD and XOR; read index for word_out.
- data_in  input  WIDTH  operand word.
- in_valid  input  1  op/addr/data_in are valid this cycle.
- in_ready  output  1  bank accepts the presented op this cycle.
- word_out  output  WIDTH  registered word at addr (combinational read).
- bank_out  output  DEPTH*WIDTH  all words, flattened; word i at bits [i*WIDTH +: WIDTH].
- count  output  ADDR_W+1  number of valid words.
- full  output  1  count == DEPTH.
- shift_out  output  WIDTH  word evicted by SHIFT.
- shift_out_valid  output  1  shift_out holds an undrained word.
- shift_out_ready  input  1  consumer takes shift_out this cycle.

## Operation
- Per-word state: data_q[i] (WIDTH bits) and valid_q[i] (1 bit). Output register: out_q and out_valid_q.
- An op is accepted when in_valid && in_ready. Non-accepted cycles leave the bank unchanged.
- RB_HOLD: no change. in_ready is always 1.
- RB_LOAD: data_q[addr] ← data_in and valid_q[addr] ← 1. in_ready is always 1.
- RB_XOR: data_q[addr] ← data_q[addr] ^ data_in and valid_q[addr] ← 1. An invalid word is zero, so XOR onto it equals a load.
- RB_SHIFT: words move i → i+1 (data and valid), and data_q[0] ← data_in with valid_q[0] ← 1.
  - The old word DEPTH-1 is captured into out_q only if valid_q[DEPTH-1] was 1; out_valid_q is then set.
  - If valid_q[DEPTH-1] was 0, the evicted word is dropped.
- in_ready for RB_SHIFT = !(valid_q[DEPTH-1] && out_valid_q && !shift_out_ready). Eviction never overwrites an undrained word.
- If out_q is drained and refilled in the same cycle, the new word replaces it and out_valid_q stays 1.
- addr ≥ DEPTH: LOAD and XOR are accepted but do not write. word_out reads 0.
- count = popcount(valid_q). full = (count == DEPTH). Both are derived, not stored.
- clear: zeroes data_q, valid_q, out_q and out_valid_q. It overrides any op accepted in the same cycle, which is dropped. in_ready is unaffected.
- reset: same effect as clear.

## Timing
- Reset values: word_out = 0, bank_out = 0, count = 0, full = 0, shift_out = 0, shift_out_valid = 0. in_ready follows the in_ready equations above.
- Write latency is 1 cycle. An op accepted at edge N is visible on word_out, bank_out and count after edge N.
- word_out, bank_out, count, full and in_ready are combinational from registers, op and shift_out_ready. Registers feed no combinational path back to inputs.
- shift_out_valid rises the cycle after the evicting SHIFT. It stays high until a cycle where shift_out_ready is 1 and no new eviction occurs.
- Throughput is one op per cycle. A continuous SHIFT stream with shift_out_ready held at 1 never stalls.
- Reset asserted mid-stream discards all contents at that edge; the bank is usable the next cycle.

## Structure
- ascon_params gains typedef enum logic [1:0] regbank_op_e {RB_HOLD, RB_LOAD, RB_XOR, RB_SHIFT}. WORD_SIZE is reused as the default width.
- Natural sub-module: word_slot, one per word. It holds data and valid and has a next-value mux (hold/load/xor/shift-from-neighbour/clear), and is instantiated DEPTH times with a generate loop. The output register and handshake logic live in the top module.

## Test plan
Configuration: WIDTH=64, DEPTH=5.
- Reset then idle → all outputs 0; in_ready=1 for every op.
- LOAD addr 2 with 0xDEADBEEF00000000, then XOR addr 2 with 0x00000000CAFEF00D → word_out@2 = 0xDEADBEEFCAFEF00D; count=1.
- 6 SHIFTs of words 1..6 with shift_out_ready=1 → after the 5th, full=1. The 6th evicts word 1: shift_out=1 and shift_out_valid=1 for one cycle. data_q[0]=6.
- Full bank with shift_out_valid=1 and shift_out_ready=0 → SHIFT sees in_ready=0 and the bank is unchanged. Raising ready gives in_ready=1; SHIFT is accepted and the next word is evicted.
- LOAD addr 7 (out of range) → no word changes; word_out with addr=7 reads 0.
- clear asserted with an accepted LOAD addr 0 → all words 0, count=0, shift_out_valid=0, and the LOAD is dropped.

Source files
------------

// File: rtl/word_regbank_pkg.sv
// Shared types and default sizing for the multi-word state register bank.
package word_regbank_pkg;

    localparam int unsigned WORD_SIZE     = 64;
    localparam int unsigned DEFAULT_DEPTH = 5;

    typedef enum logic [1:0] {
        RB_HOLD  = 2'd0,
        RB_LOAD  = 2'd1,
        RB_XOR   = 2'd2,
        RB_SHIFT = 2'd3
    } regbank_op_e;

endpackage

// File: rtl/word_regbank_if.sv
// Operation/handshake bundle between the bank and its I/O controller.
interface word_regbank_if
    import word_regbank_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_SIZE,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    regbank_op_e              op;
    logic [ADDR_W-1:0]        addr;
    logic [WIDTH-1:0]         data_in;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         word_out;
    logic [DEPTH*WIDTH-1:0]   bank_out;
    logic [ADDR_W:0]          count;
    logic                     full;
    logic [WIDTH-1:0]         shift_out;
    logic                     shift_out_valid;
    logic                     shift_out_ready;

    modport master (
        output op, addr, data_in, in_valid, shift_out_ready,
        input  in_ready, word_out, bank_out, count, full, shift_out, shift_out_valid
    );

    modport slave (
        input  op, addr, data_in, in_valid, shift_out_ready,
        output in_ready, word_out, bank_out, count, full, shift_out, shift_out_valid
    );

endinterface

// File: rtl/word_regbank_slot.sv
// One bank word: data plus valid flag with a hold/load/xor/shift/clear next-value mux.
module word_regbank_slot
    import word_regbank_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_en,
    input  logic             xor_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] shift_data,
    input  logic             shift_valid,
    output logic [WIDTH-1:0] data_q,
    output logic             valid_q
);

    logic [WIDTH-1:0] data_d;
    logic             valid_d;

    // An invalid word reads as zero, so XOR onto it degenerates to a load.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (shift_en) begin
            data_d  = shift_data;
            valid_d = shift_valid;
        end else if (load_en) begin
            data_d  = data_in;
            valid_d = 1'b1;
        end else if (xor_en) begin
            data_d  = valid_q ? (data_q ^ data_in) : data_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/word_regbank.sv
// DEPTH x WIDTH state bank with indexed load/xor, serial shift-in and a
// handshaked shift-out register for the evicted top word.
module word_regbank
    import word_regbank_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_SIZE,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    word_regbank_if.slave  bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]       data_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [WIDTH-1:0]       out_q;
    logic                   out_valid_q;

    logic                   is_shift;
    logic                   in_ready_c;
    logic                   accept;
    logic                   addr_ok;
    logic                   evict;
    logic [WIDTH-1:0]       word_rd;
    logic [DEPTH*WIDTH-1:0] bank_flat;
    logic [CNT_W-1:0]       cnt;

    // Shift is only held off when it would overwrite an undrained eviction.
    always_comb begin
        is_shift   = (bus.op == RB_SHIFT);
        in_ready_c = !(is_shift && valid_q[DEPTH-1] && out_valid_q && !bus.shift_out_ready);
        accept     = bus.in_valid && in_ready_c;
        addr_ok    = (CNT_W'(bus.addr) < CNT_W'(DEPTH));
        evict      = accept && is_shift && valid_q[DEPTH-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic             hit;
        logic [WIDTH-1:0] nb_data;
        logic             nb_valid;

        assign hit = addr_ok && (bus.addr == ADDR_W'(i));

        if (i == 0) begin : g_head
            assign nb_data  = bus.data_in;
            assign nb_valid = 1'b1;
        end else begin : g_body
            assign nb_data  = data_q[i-1];
            assign nb_valid = valid_q[i-1];
        end

        word_regbank_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .clear       (clear),
            .load_en     (accept && (bus.op == RB_LOAD) && hit),
            .xor_en      (accept && (bus.op == RB_XOR) && hit),
            .shift_en    (accept && is_shift),
            .data_in     (bus.data_in),
            .shift_data  (nb_data),
            .shift_valid (nb_valid),
            .data_q      (data_q[i]),
            .valid_q     (valid_q[i])
        );
    end

    // Read mux; out-of-range indices fall through to zero.
    always_comb begin
        word_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_ok && (bus.addr == ADDR_W'(i))) begin
                word_rd = data_q[i];
            end
        end
    end

    always_comb begin
        bank_flat = '0;
        cnt       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bank_flat[i*WIDTH +: WIDTH] = data_q[i];
            cnt = cnt + CNT_W'(valid_q[i]);
        end
    end

    // A same-cycle drain and refill keeps the register valid with the new word.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (evict) begin
            out_q       <= data_q[DEPTH-1];
            out_valid_q <= 1'b1;
        end else if (bus.shift_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.word_out        = word_rd;
    assign bus.bank_out        = bank_flat;
    assign bus.count           = cnt;
    assign bus.full            = (cnt == CNT_W'(DEPTH));
    assign bus.shift_out       = out_q;
    assign bus.shift_out_valid = out_valid_q;

endmodule

// File: tb/tb_word_regbank.sv
// Self-checking bench for word_regbank: directed vector table plus randomized
// traffic compared against an array-based reference model of the bank.
module tb_word_regbank;
    import word_regbank_pkg::*;

    localparam int unsigned W = 64;
    localparam int unsigned D = 5;
    localparam int unsigned BW = 320;

    logic clk;
    logic reset;
    logic clear;

    int checks = 0;
    int errors = 0;

    word_regbank_if #(.WIDTH(W), .DEPTH(D)) bus ();

    word_regbank #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  addr;
        logic [63:0] data;
        logic        vld;
        logic        sor;
        logic        clr;
        logic        e_ir;
        logic [63:0] e_wo;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_sov;
        logic [63:0] e_so;
    } vec_t;

    vec_t tbl [19];

    // Reference model state
    logic [63:0] m_data [D];
    logic        m_valid [D];
    logic [63:0] m_out;
    logic        m_out_v;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [2:0] addr, input logic [63:0] data,
                                input logic vld, input logic sor, input logic clr, input logic e_ir,
                                input logic [63:0] e_wo, input logic [3:0] e_cnt, input logic e_full,
                                input logic e_sov, input logic [63:0] e_so);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.vld = vld; v.sor = sor; v.clr = clr;
        v.e_ir = e_ir; v.e_wo = e_wo; v.e_cnt = e_cnt; v.e_full = e_full; v.e_sov = e_sov; v.e_so = e_so;
        return v;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [2:0] addr, input logic [63:0] data,
                         input logic vld, input logic sor, input logic clr, input logic rst);
        bus.op              = regbank_op_e'(op);
        bus.addr            = addr;
        bus.data_in         = data;
        bus.in_valid        = vld;
        bus.shift_out_ready = sor;
        clear               = clr;
        reset               = rst;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < D; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
        m_out   = '0;
        m_out_v = 1'b0;
    endfunction

    function automatic logic model_ready(input logic [1:0] op, input logic sor);
        return (op == 2'd3) ? !(m_valid[D-1] && m_out_v && !sor) : 1'b1;
    endfunction

    function automatic void model_step(input logic [1:0] op, input logic [2:0] addr, input logic [63:0] data,
                                       input logic vld, input logic sor, input logic clr, input logic rst);
        logic        acc;
        logic        ev;
        logic [63:0] ev_word;
        acc = vld && model_ready(op, sor);
        ev  = 1'b0;
        ev_word = '0;
        if (rst || clr) begin
            model_reset();
            return;
        end
        if (acc) begin
            if (op == 2'd1 && addr < 3'(D)) begin
                m_data[addr]  = data;
                m_valid[addr] = 1'b1;
            end else if (op == 2'd2 && addr < 3'(D)) begin
                m_data[addr]  = m_data[addr] ^ data;
                m_valid[addr] = 1'b1;
            end else if (op == 2'd3) begin
                ev      = m_valid[D-1];
                ev_word = m_data[D-1];
                for (int i = D - 1; i > 0; i--) begin
                    m_data[i]  = m_data[i-1];
                    m_valid[i] = m_valid[i-1];
                end
                m_data[0]  = data;
                m_valid[0] = 1'b1;
            end
        end
        if (ev) begin
            m_out   = ev_word;
            m_out_v = 1'b1;
        end else if (sor) begin
            m_out_v = 1'b0;
        end
    endfunction

    function automatic logic [BW-1:0] model_bank();
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < D; i++) b[i*W +: W] = m_data[i];
        return b;
    endfunction

    function automatic logic [3:0] model_count();
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < D; i++) c = c + 4'(m_valid[i]);
        return c;
    endfunction

    initial begin
        drive(2'd0, 3'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_word_out", BW'(bus.word_out), '0);
        check("rst_bank_out", BW'(bus.bank_out), '0);
        check("rst_count", BW'(bus.count), '0);
        check("rst_full", BW'(bus.full), '0);
        check("rst_shift_out", BW'(bus.shift_out), '0);
        check("rst_shift_out_valid", BW'(bus.shift_out_valid), '0);
        reset = 1'b0;
        for (int o = 0; o < 4; o++) begin
            drive(2'(o), 3'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            check($sformatf("idle_in_ready_op%0d", o), BW'(bus.in_ready), BW'(1));
        end

        //          op    addr  data                    vld sor clr ir  wo                     cnt  full sov so
        tbl[0]  = mk(2'd1, 3'd2, 64'hDEADBEEF00000000, 1, 0, 0, 1, 64'hDEADBEEF00000000, 4'd1, 0, 0, 64'd0);
        tbl[1]  = mk(2'd2, 3'd2, 64'h00000000CAFEF00D, 1, 0, 0, 1, 64'hDEADBEEFCAFEF00D, 4'd1, 0, 0, 64'd0);
        tbl[2]  = mk(2'd0, 3'd0, 64'd0,                0, 0, 1, 1, 64'd0,                4'd0, 0, 0, 64'd0);
        tbl[3]  = mk(2'd3, 3'd0, 64'd1,                1, 1, 0, 1, 64'd1,                4'd1, 0, 0, 64'd0);
        tbl[4]  = mk(2'd3, 3'd0, 64'd2,                1, 1, 0, 1, 64'd2,                4'd2, 0, 0, 64'd0);
        tbl[5]  = mk(2'd3, 3'd0, 64'd3,                1, 1, 0, 1, 64'd3,                4'd3, 0, 0, 64'd0);
        tbl[6]  = mk(2'd3, 3'd0, 64'd4,                1, 1, 0, 1, 64'd4,                4'd4, 0, 0, 64'd0);
        tbl[7]  = mk(2'd3, 3'd0, 64'd5,                1, 1, 0, 1, 64'd5,                4'd5, 1, 0, 64'd0);
        tbl[8]  = mk(2'd3, 3'd0, 64'd6,                1, 1, 0, 1, 64'd6,                4'd5, 1, 1, 64'd1);
        tbl[9]  = mk(2'd0, 3'd0, 64'd0,                1, 1, 0, 1, 64'd6,                4'd5, 1, 0, 64'd0);
        tbl[10] = mk(2'd3, 3'd0, 64'd7,                1, 0, 0, 1, 64'd7,                4'd5, 1, 1, 64'd2);
        tbl[11] = mk(2'd3, 3'd0, 64'd8,                1, 0, 0, 0, 64'd7,                4'd5, 1, 1, 64'd2);
        tbl[12] = mk(2'd3, 3'd0, 64'd8,                1, 1, 0, 1, 64'd8,                4'd5, 1, 1, 64'd3);
        tbl[13] = mk(2'd1, 3'd7, 64'hFFFF,             1, 0, 0, 1, 64'd0,                4'd5, 1, 1, 64'd3);
        tbl[14] = mk(2'd0, 3'd4, 64'd0,                1, 0, 0, 1, 64'd4,                4'd5, 1, 1, 64'd3);
        tbl[15] = mk(2'd1, 3'd0, 64'h55,               1, 0, 1, 1, 64'd0,                4'd0, 0, 0, 64'd0);
        tbl[16] = mk(2'd0, 3'd0, 64'd0,                1, 0, 0, 1, 64'd0,                4'd0, 0, 0, 64'd0);
        tbl[17] = mk(2'd1, 3'd1, 64'hAA,               0, 0, 0, 1, 64'd0,                4'd0, 0, 0, 64'd0);
        tbl[18] = mk(2'd2, 3'd1, 64'h0F,               1, 0, 0, 1, 64'h0F,               4'd1, 0, 0, 64'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].vld, tbl[i].sor, tbl[i].clr, 1'b0);
            #1;
            check($sformatf("vec%0d_in_ready", i), BW'(bus.in_ready), BW'(tbl[i].e_ir));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_word_out", i), BW'(bus.word_out), BW'(tbl[i].e_wo));
            check($sformatf("vec%0d_count", i), BW'(bus.count), BW'(tbl[i].e_cnt));
            check($sformatf("vec%0d_full", i), BW'(bus.full), BW'(tbl[i].e_full));
            check($sformatf("vec%0d_sov", i), BW'(bus.shift_out_valid), BW'(tbl[i].e_sov));
            if (tbl[i].e_sov)
                check($sformatf("vec%0d_shift_out", i), BW'(bus.shift_out), BW'(tbl[i].e_so));
        end

        // Randomized traffic from a clean bank against the reference model.
        drive(2'd0, 3'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [1:0]  r_op;
            logic [2:0]  r_addr;
            logic [63:0] r_data;
            logic        r_vld, r_sor, r_clr, r_rst;
            r_op   = 2'($urandom_range(0, 3));
            r_addr = 3'($urandom_range(0, 7));
            r_data = {$urandom(), $urandom()};
            r_vld  = ($urandom_range(0, 3) != 0);
            r_sor  = ($urandom_range(0, 1) != 0);
            r_clr  = ($urandom_range(0, 59) == 0);
            r_rst  = ($urandom_range(0, 149) == 0);
            drive(r_op, r_addr, r_data, r_vld, r_sor, r_clr, r_rst);
            #1;
            check("rand_in_ready", BW'(bus.in_ready), BW'(model_ready(r_op, r_sor)));
            model_step(r_op, r_addr, r_data, r_vld, r_sor, r_clr, r_rst);
            @(posedge clk);
            #1;
            check("rand_word_out", BW'(bus.word_out), BW'((r_addr < 3'(D)) ? m_data[r_addr] : 64'd0));
            check("rand_bank_out", BW'(bus.bank_out), model_bank());
            check("rand_count", BW'(bus.count), BW'(model_count()));
            check("rand_full", BW'(bus.full), BW'(model_count() == 4'(D)));
            check("rand_sov", BW'(bus.shift_out_valid), BW'(m_out_v));
            if (m_out_v)
                check("rand_shift_out", BW'(bus.shift_out), BW'(m_out));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
